// File: rtl/pwm_capture_decoder.sv
// +--------------------------------------------------------------------------+
// | pwm_capture_decoder: measures servo PWM high time and period, decodes    |
// | the commanded position and flags duty/period/timeout errors. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_capture_decoder #(
  parameter int unsigned DUTY_TOL   = 50,
  parameter int unsigned PER_TOL    = 500,
  parameter int unsigned TIMEOUT    = 1100000,
  parameter int unsigned POS1_HIGH  = 25000,
  parameter int unsigned POS2_HIGH  = 75000,
  parameter int unsigned POS3_HIGH  = 125000,
  parameter int unsigned PERIOD_NOM = 1000000
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        Pwm_i,
  output logic [16:0] High_cnt_o,
  output logic [19:0] Period_cnt_o,
  output logic [1:0]  Sel_o,
  output logic        Valid_o,
  output logic        Duty_err_o,
  output logic        Period_err_o,
  output logic        Timeout_o
);

  localparam logic [16:0] HIGH_MAX = 17'h1FFFF;
  localparam logic [19:0] PER_MAX  = 20'hFFFFF;
  // The period counter saturates at 20 bits, so a larger TIMEOUT is clamped
  // to the saturation value; otherwise the default would never fire.
  localparam logic [19:0] TO_LIMIT = (TIMEOUT >= 32'h000FFFFF) ? PER_MAX : 20'(TIMEOUT);
  localparam logic [19:0] TO_CNT   = (TO_LIMIT == 20'd0) ? 20'd0 : TO_LIMIT - 20'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        sync3_q, sync3_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic [16:0] high_cnt_q, high_cnt_d;
  logic [19:0] per_cnt_q, per_cnt_d;
  logic [16:0] high_lat_q, high_lat_d;
  logic [16:0] high_out_q, high_out_d;
  logic [19:0] per_out_q, per_out_d;
  logic [1:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        duty_err_q, duty_err_d;
  logic        per_err_q, per_err_d;
  logic        timeout_q, timeout_d;

  logic [16:0] high_inc;
  logic [19:0] per_inc;
  logic        per_expired;
  logic [1:0]  sel_dec;
  logic        per_bad;

  function automatic logic in_window(input logic [31:0] x, input logic [31:0] c,
                                     input logic [31:0] tol);
    logic [31:0] diff;
    diff = (x >= c) ? (x - c) : (c - x);
    return (diff <= tol);
  endfunction

  // Edge pulses are registered so that level and edge stay aligned with sync3_q.
  always_comb begin
    sync1_d = Pwm_i;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
    fall_d  = ~sync2_q & sync3_q;
  end

  always_comb begin
    high_inc    = (high_cnt_q == HIGH_MAX) ? HIGH_MAX : high_cnt_q + 17'd1;
    per_inc     = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 20'd1;
    per_expired = (per_cnt_q >= TO_CNT);

    sel_dec = 2'd0;
    if (in_window({15'd0, high_lat_q}, POS1_HIGH, DUTY_TOL)) begin
      sel_dec = 2'd1;
    end else if (in_window({15'd0, high_lat_q}, POS2_HIGH, DUTY_TOL)) begin
      sel_dec = 2'd2;
    end else if (in_window({15'd0, high_lat_q}, POS3_HIGH, DUTY_TOL)) begin
      sel_dec = 2'd3;
    end
    per_bad = ~in_window({12'd0, per_inc}, PERIOD_NOM, PER_TOL);
  end

  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    per_cnt_d  = per_cnt_q;
    high_lat_d = high_lat_q;
    high_out_d = high_out_q;
    per_out_d  = per_out_q;
    sel_d      = sel_q;
    valid_d    = 1'b0;
    duty_err_d = duty_err_q;
    per_err_d  = per_err_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (rise_q) begin
          state_d    = S_HIGH;
          high_cnt_d = 17'd0;
          per_cnt_d  = 20'd0;
          timeout_d  = 1'b0;
        end
      end
      S_HIGH: begin
        per_cnt_d = per_inc;
        if (per_expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          sel_d     = 2'd0;
        end else if (fall_q) begin
          // The cycle that detected the rise was already high, hence the +1.
          high_lat_d = high_inc;
          state_d    = S_LOW;
        end else if (sync3_q) begin
          high_cnt_d = high_inc;
        end
      end
      S_LOW: begin
        per_cnt_d = per_inc;
        if (rise_q) begin
          high_out_d = high_lat_q;
          per_out_d  = per_inc;
          sel_d      = sel_dec;
          duty_err_d = (sel_dec == 2'd0);
          per_err_d  = per_bad;
          valid_d    = 1'b1;
          high_cnt_d = 17'd0;
          per_cnt_d  = 20'd0;
          state_d    = S_HIGH;
        end else if (per_expired) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          sel_d     = 2'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      high_cnt_q <= 17'd0;
      per_cnt_q  <= 20'd0;
      high_lat_q <= 17'd0;
      high_out_q <= 17'd0;
      per_out_q  <= 20'd0;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
      duty_err_q <= 1'b0;
      per_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      high_cnt_q <= high_cnt_d;
      per_cnt_q  <= per_cnt_d;
      high_lat_q <= high_lat_d;
      high_out_q <= high_out_d;
      per_out_q  <= per_out_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      duty_err_q <= duty_err_d;
      per_err_q  <= per_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign High_cnt_o   = high_out_q;
  assign Period_cnt_o = per_out_q;
  assign Sel_o        = sel_q;
  assign Valid_o      = valid_q;
  assign Duty_err_o   = duty_err_q;
  assign Period_err_o = per_err_q;
  assign Timeout_o    = timeout_q;

endmodule

`default_nettype wire
